// File: rtl/status_monitor.sv
// Stage/error/timeout pass-fail monitor with debounced stage acceptance.
// Optional history FIFO of accepted stages is built when STATUS_MON_HIST_EN is defined.
module status_monitor #(
  parameter int                 STAGE_W    = 8,
  parameter int                 TIMER_W    = 24,
  parameter int                 STABLE     = 4,
  parameter logic [STAGE_W-1:0] START_CODE = {STAGE_W{1'b1}},
  parameter logic [STAGE_W-1:0] PASS_CODE  = {{(STAGE_W-1){1'b1}}, 1'b0},
  parameter bit                 MONOTONIC  = 1'b1,
  parameter int                 HIST_DEPTH = 8
) (
  input  logic               clock,
  input  logic               RSTB,
  input  logic               enable,
  input  logic               clear,
  input  logic [STAGE_W-1:0] stage_in,
  input  logic               error_in,
  input  logic [TIMER_W-1:0] timeout_limit,
  output logic [1:0]         state,
  output logic               pass,
  output logic               fail,
  output logic [1:0]         fail_code,
  output logic [STAGE_W-1:0] cur_stage,
  output logic [7:0]         stage_count,
  output logic [STAGE_W-1:0] hist_data,
  output logic               hist_valid,
  input  logic               hist_ready,
  output logic               hist_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [3:0] STABLE_C = 4'(STABLE);

  logic [STAGE_W-1:0] stage_s1_q, stage_s2_q, stage_s3_q;
  logic               err_s1_q, err_s2_q;
  logic [3:0]         stab_q, stab_d;
  logic [STAGE_W-1:0] cur_q;
  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
  logic [7:0]         count_q, count_d;
  logic [1:0]         code_q, code_d;
  logic               pass_q, fail_q;
  logic               order_q, order_d;
  logic               accept, run_accept;

  // stage_s3_q holds the previous synced sample for the stability compare
  always_comb begin
    stab_d = stab_q;
    if (stage_s2_q == stage_s3_q) begin
      if (stab_q != STABLE_C) stab_d = stab_q + 4'd1;
    end else begin
      stab_d = '0;
    end
  end

  assign accept     = (stab_d == STABLE_C) && (stage_s2_q != cur_q);
  assign run_accept = accept && (state_q == ST_RUN);
  assign timer_inc  = (timer_q == {TIMER_W{1'b1}}) ? timer_q : timer_q + 1'b1;

  always_comb begin
    order_d = 1'b0;
    if (!clear && MONOTONIC && run_accept && (stage_s2_q < cur_q) &&
        (cur_q != START_CODE) && (stage_s2_q != PASS_CODE))
      order_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    timer_d = timer_q;
    count_d = count_q;
    if (clear) begin
      state_d = ST_IDLE;
      code_d  = 2'd0;
      timer_d = '0;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timer_d = '0;
          count_d = '0;
          if (enable && cur_q == START_CODE) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!enable) begin
            state_d = ST_IDLE;
            timer_d = '0;
            count_d = '0;
          end else begin
            timer_d = run_accept ? '0 : timer_inc;
            if (run_accept && count_q != 8'hFF) count_d = count_q + 8'd1;
            // timeout fires on the edge where the timer reaches the limit
            if (err_s2_q) begin
              state_d = ST_FAIL;
              code_d  = 2'd1;
            end else if (cur_q == PASS_CODE) begin
              state_d = ST_PASS;
            end else if (order_q) begin
              state_d = ST_FAIL;
              code_d  = 2'd3;
            end else if (timeout_limit != '0 && timer_d == timeout_limit) begin
              state_d = ST_FAIL;
              code_d  = 2'd2;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      stage_s1_q <= '0;
      stage_s2_q <= '0;
      stage_s3_q <= '0;
      err_s1_q   <= 1'b0;
      err_s2_q   <= 1'b0;
      stab_q     <= '0;
      cur_q      <= '0;
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      count_q    <= '0;
      code_q     <= 2'd0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      order_q    <= 1'b0;
    end else begin
      stage_s1_q <= stage_in;
      stage_s2_q <= stage_s1_q;
      stage_s3_q <= stage_s2_q;
      err_s1_q   <= error_in;
      err_s2_q   <= err_s1_q;
      stab_q     <= stab_d;
      if (accept) cur_q <= stage_s2_q;
      state_q    <= state_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      code_q     <= code_d;
      pass_q     <= (state_d == ST_PASS);
      fail_q     <= (state_d == ST_FAIL);
      order_q    <= order_d;
    end
  end

  assign state       = state_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign fail_code   = code_q;
  assign cur_stage   = cur_q;
  assign stage_count = count_q;

`ifdef STATUS_MON_HIST_EN
  localparam int AW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(HIST_DEPTH);

  logic [STAGE_W-1:0] hist_mem_q [HIST_DEPTH];
  logic [AW-1:0]      wr_q, rd_q;
  logic [AW:0]        cnt_q;
  logic               ovf_q;
  logic               push, pop, full, do_write;

  assign push     = run_accept;
  assign pop      = (cnt_q != '0) && hist_ready;
  assign full     = (cnt_q == DEPTH_C);
  assign do_write = push && (!full || pop);

  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem_q[i] <= '0;
    end else if (do_write && !clear) begin
      hist_mem_q[wr_q] <= stage_s2_q;
    end
  end

  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_write) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
      case ({do_write, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign hist_data  = (cnt_q != '0) ? hist_mem_q[rd_q] : '0;
  assign hist_valid = (cnt_q != '0);
  assign hist_ovf   = ovf_q;
`else
  logic unused_hist_ready;
  assign unused_hist_ready = hist_ready;
  assign hist_data         = '0;
  assign hist_valid        = 1'b0;
  assign hist_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_status_monitor.sv
// Bench for status_monitor: scenario table plus hand-timed sequences;
// a scoreboard queue predicts every cur_stage change.
module tb_status_monitor;

  logic        clock = 1'b0;
  logic        RSTB, enable, clear, error_in, hist_ready;
  logic [7:0]  stage_in;
  logic [23:0] timeout_limit;
  logic [1:0]  state, fail_code;
  logic        pass, fail, hist_valid, hist_ovf;
  logic [7:0]  cur_stage, stage_count, hist_data;

  status_monitor dut (
    .clock(clock), .RSTB(RSTB), .enable(enable), .clear(clear),
    .stage_in(stage_in), .error_in(error_in), .timeout_limit(timeout_limit),
    .state(state), .pass(pass), .fail(fail), .fail_code(fail_code),
    .cur_stage(cur_stage), .stage_count(stage_count),
    .hist_data(hist_data), .hist_valid(hist_valid), .hist_ready(hist_ready),
    .hist_ovf(hist_ovf)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]      n;
    logic [4:0][7:0] codes;
    logic [23:0]     limit;
    logic [1:0]      st;
    logic [1:0]      code;
    logic [7:0]      cnt;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_seen = 8'd0;
  logic [7:0] drv_prev  = 8'd0;
  vec_t       vec[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [7:0] c0, c1, c2, c3, c4,
                              input logic [23:0] lim, input logic [1:0] st, code,
                              input logic [7:0] cnt);
    vec_t r;
    r.n = 4'(n);
    r.codes[0] = c0; r.codes[1] = c1; r.codes[2] = c2; r.codes[3] = c3; r.codes[4] = c4;
    r.limit = lim; r.st = st; r.code = code; r.cnt = cnt;
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_stage(input logic [7:0] v, input int n);
    if (v != drv_prev) exp_q.push_back(v);
    drv_prev = v;
    stage_in = v;
    tick(n);
  endtask

  task automatic do_reset();
    RSTB = 1'b0; stage_in = 8'd0; error_in = 1'b0; enable = 1'b0;
    clear = 1'b0; hist_ready = 1'b0; timeout_limit = 24'd0;
    drv_prev = 8'd0;
    exp_q.delete();
    tick(3);
    RSTB = 1'b1;
    tick(3);
  endtask

  task automatic hist_pop(input string name, input logic [7:0] exp);
    check({name, "_valid"}, hist_valid, 1);
    check({name, "_data"}, hist_data, exp);
    hist_ready = 1'b1;
    tick(1);
    hist_ready = 1'b0;
  endtask

  // Scoreboard consumer: each observed cur_stage change must match the next prediction
  initial begin
    forever begin
      @(negedge clock);
      if (!RSTB) begin
        last_seen = 8'd0;
      end else if (cur_stage !== last_seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cur_stage_unexpected: got %0h expected %0h", cur_stage, last_seen);
        end else begin
          check("cur_stage_seq", cur_stage, exp_q.pop_front());
        end
        last_seen = cur_stage;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int w;
    vec[0] = mk(5, 8'hFF, 8'd0, 8'd1, 8'd2, 8'hFE, 24'd1000, 2'd2, 2'd0, 8'd4);
    vec[1] = mk(4, 8'hFF, 8'd0, 8'd3, 8'd1, 8'd0,  24'd1000, 2'd3, 2'd3, 8'd3);
    vec[2] = mk(4, 8'hFF, 8'd1, 8'd2, 8'd3, 8'd0,  24'd1000, 2'd1, 2'd0, 8'd3);
    vec[3] = mk(2, 8'hFF, 8'd5, 8'd0, 8'd0, 8'd0,  24'd30,   2'd3, 2'd2, 8'd1);
    vec[4] = mk(3, 8'hFF, 8'd9, 8'hFE, 8'd0, 8'd0, 24'd1000, 2'd2, 2'd0, 8'd2);

    do_reset();
    check("rst_state", state, 0);
    check("rst_pass_fail", {pass, fail}, 0);
    check("rst_fail_code", fail_code, 0);
    check("rst_cur_stage", cur_stage, 0);
    check("rst_count", stage_count, 0);
    check("rst_hist", {hist_valid, hist_ovf, hist_data}, 0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      timeout_limit = vec[v].limit;
      enable = 1'b1;
      for (int k = 0; k < int'(vec[v].n); k++) drive_stage(vec[v].codes[k], 20);
      tick(30);
      $display("vector %0d: state=%0d fail_code=%0d count=%0d", v, state, fail_code, stage_count);
      check("vec_state", state, vec[v].st);
      check("vec_fail_code", fail_code, vec[v].code);
      check("vec_count", stage_count, vec[v].cnt);
      check("vec_pass", pass, vec[v].st == 2'd2);
      check("vec_fail", fail, vec[v].st == 2'd3);
`ifdef STATUS_MON_HIST_EN
      for (int k = 1; k < int'(vec[v].n); k++) hist_pop("vec_hist", vec[v].codes[k]);
`endif
      check("vec_hist_empty", hist_valid, 0);
      check("vec_hist_ovf", hist_ovf, 0);
    end

    // error pulse: FAIL lands on the third edge after the rising input
    do_reset();
    timeout_limit = 24'd1000;
    enable = 1'b1;
    drive_stage(8'hFF, 20); drive_stage(8'd0, 20); drive_stage(8'd3, 20);
    check("err_pre_state", state, 1);
    error_in = 1'b1;
    tick(2);
    check("err_edge2_state", state, 1);
    tick(1);
    check("err_edge3_state", state, 3);
    check("err_edge3_code", fail_code, 1);
    error_in = 1'b0;
    tick(10);
    check("err_sticky_fail", fail, 1);
    check("err_sticky_code", fail_code, 1);
    $display("error: state=%0d fail_code=%0d", state, fail_code);

    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_state", state, 0);
    check("clr_code", fail_code, 0);
    check("clr_fail", fail, 0);
    check("clr_count", stage_count, 0);
    check("clr_cur_stage", cur_stage, 3);
    check("clr_hist", hist_valid, 0);

    // timeout boundary: limit=50 counted from the accepting edge
    do_reset();
    timeout_limit = 24'd50;
    enable = 1'b1;
    drive_stage(8'hFF, 20);
    drive_stage(8'd2, 0);
    w = 0;
    while (cur_stage !== 8'd2 && w < 20) begin
      tick(1);
      w++;
    end
    check("to_accept", cur_stage, 2);
    tick(49);
    check("to_edge49_state", state, 1);
    tick(1);
    check("to_edge50_state", state, 3);
    check("to_edge50_code", fail_code, 2);
    $display("timeout: state=%0d fail_code=%0d", state, fail_code);

    // limit 0 never times out; then a short glitch and an async reset mid-RUN
    do_reset();
    enable = 1'b1;
    drive_stage(8'hFF, 20); drive_stage(8'd2, 20);
    tick(10000);
    check("nolimit_state", state, 1);
    stage_in = 8'd7;
    tick(2);
    stage_in = 8'd2;
    tick(20);
    check("glitch_cur_stage", cur_stage, 2);
    check("glitch_state", state, 1);
    #3;
    RSTB = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_flags", {pass, fail, fail_code}, 0);
    check("arst_cur_stage", cur_stage, 0);
    check("arst_count", stage_count, 0);
    check("arst_hist", {hist_valid, hist_ovf}, 0);
    $display("async reset: state=%0d cur_stage=%0h", state, cur_stage);

    // enable drop in RUN returns to IDLE with counters cleared
    do_reset();
    enable = 1'b1;
    drive_stage(8'hFF, 20); drive_stage(8'd1, 20);
    check("en_run_count", stage_count, 1);
    enable = 1'b0;
    tick(1);
    check("en_drop_state", state, 0);
    check("en_drop_count", stage_count, 0);

    // ten changes into an eight-entry history with no pops
    do_reset();
    enable = 1'b1;
    drive_stage(8'hFF, 20);
    for (int k = 1; k <= 10; k++) drive_stage(8'(k), 20);
    tick(10);
    check("ovf_count", stage_count, 10);
    check("ovf_state", state, 1);
`ifdef STATUS_MON_HIST_EN
    check("ovf_flag", hist_ovf, 1);
    for (int k = 1; k <= 8; k++) hist_pop("ovf_hist", 8'(k));
    check("ovf_drained", hist_valid, 0);
`else
    check("ovf_flag", hist_ovf, 0);
    check("ovf_valid", hist_valid, 0);
`endif
    $display("history: count=%0d ovf=%0d", stage_count, hist_ovf);

    check("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
